// File: rtl/bullet_pool_ctrl.sv
// Bullet pool controller: Avalon-MM register block owning a small pool of
// horizontal projectiles. Software spawns/kills through registers; every
// enabled frame_tick starts a sweep that advances one slot per cycle and
// retires bullets that would leave [X_MIN, X_MAX].

// One bullet slot: position, direction and occupancy.
module bullet_slot #(
  parameter int X_WIDTH = 10,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [X_WIDTH-1:0] load_x_i,
  input  logic               load_dir_i,
  input  logic               step_i,
  input  logic [3:0]         speed_i,
  input  logic               kill_i,
  output logic [X_WIDTH-1:0] x_o,
  output logic               active_o
);
  localparam logic [X_WIDTH:0] MAX_W = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0] MIN_W = (X_WIDTH+1)'(X_MIN);

  logic [X_WIDTH-1:0] x_q, x_d;
  logic               dir_q, dir_d;
  logic               act_q, act_d;
  logic [X_WIDTH-1:0] spd;
  logic [X_WIDTH:0]   sum;

  assign spd      = {{(X_WIDTH-4){1'b0}}, speed_i};
  assign sum      = {1'b0, x_q} + {1'b0, spd};
  assign x_o      = x_q;
  assign active_o = act_q;

  // Next slot state: load, else one movement step; a kill always wins on occupancy.
  always_comb begin
    x_d   = x_q;
    dir_d = dir_q;
    act_d = act_q;
    if (load_i) begin
      x_d   = load_x_i;
      dir_d = load_dir_i;
      act_d = 1'b1;
    end else if (step_i && act_q) begin
      if (!dir_q) begin
        // Moving right: retire in place when the next position overshoots.
        if (sum > MAX_W) act_d = 1'b0;
        else             x_d   = sum[X_WIDTH-1:0];
      end else begin
        // Moving left: compare before subtracting so nothing wraps.
        if ({1'b0, x_q} < (MIN_W + {1'b0, spd})) act_d = 1'b0;
        else                                     x_d   = x_q - spd;
      end
    end
    if (kill_i) act_d = 1'b0;
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      dir_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      dir_q <= dir_d;
      act_q <= act_d;
    end
  end
endmodule

module bullet_pool_ctrl #(
  parameter int NUM_BULLETS = 4,
  parameter int X_WIDTH     = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int SPEED_RST   = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [2:0]                     address,
  input  logic                           chipselect,
  input  logic                           write_n,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  input  logic                           frame_tick,
  output logic [NUM_BULLETS*X_WIDTH-1:0] bullet_x,
  output logic [NUM_BULLETS-1:0]         bullet_active,
  output logic                           busy
);
  localparam int              IDX_W    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS-1);

  typedef enum logic {IDLE, UPDATE} state_e;
  typedef struct packed {
    logic               vld;
    logic               dir;
    logic [X_WIDTH-1:0] x;
  } spawn_req_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             enable_q, enable_d;
  logic [3:0]       speed_q, speed_d;
  logic             spawn_err_q, spawn_err_d;
  logic             overrun_q, overrun_d;
  spawn_req_t       pend_q, pend_d;

  logic wr_en, spawn_wr, ctrl_wr, kill_wr;
  int         spawn_raw;
  logic       spawn_ok;
  spawn_req_t wr_req;
  logic       do_alloc, free_found, set_err, set_ovr;
  logic [X_WIDTH-1:0]     alloc_x;
  logic                   alloc_dir;
  logic [NUM_BULLETS-1:0] free_oh, load_vec, step_vec, kill_vec;
  logic [NUM_BULLETS-1:0][X_WIDTH-1:0] slot_x;
  logic [3:0] mask4;
  logic       unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign spawn_wr  = wr_en && (address == 3'd0);
  assign ctrl_wr   = wr_en && (address == 3'd1);
  assign kill_wr   = wr_en && (address == 3'd2);
  assign kill_vec  = writedata[NUM_BULLETS-1:0] & {NUM_BULLETS{kill_wr}};
  assign busy      = (state_q == UPDATE);
  assign bullet_x  = slot_x;
  assign unused_wd = ^writedata[30:11];

  // Decode the SPAWN write payload and its range check.
  always_comb begin
    spawn_raw  = {22'd0, writedata[9:0]};
    spawn_ok   = (spawn_raw >= X_MIN) && (spawn_raw <= X_MAX);
    wr_req.vld = 1'b1;
    wr_req.dir = writedata[10];
    wr_req.x   = spawn_raw[X_WIDTH-1:0];
  end

  // Lowest-index free slot, one-hot.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!bullet_active[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  // Slot currently being swept.
  always_comb begin
    step_vec = '0;
    for (int i = 0; i < NUM_BULLETS; i++) step_vec[i] = busy && (idx_q == IDX_W'(i));
  end

  // Sweep FSM, spawn/pending arbitration, CTRL and sticky flag updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    enable_d    = enable_q;
    speed_d     = speed_q;
    spawn_err_d = spawn_err_q;
    overrun_d   = overrun_q;
    pend_d      = pend_q;
    do_alloc    = 1'b0;
    alloc_x     = wr_req.x;
    alloc_dir   = wr_req.dir;
    set_err     = 1'b0;
    set_ovr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && enable_q) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
        if (pend_q.vld) begin
          // Drain the queued spawn first; a same-cycle write refills the buffer.
          do_alloc   = 1'b1;
          alloc_x    = pend_q.x;
          alloc_dir  = pend_q.dir;
          pend_d.vld = 1'b0;
          if (spawn_wr) begin
            if (spawn_ok) pend_d  = wr_req;
            else          set_err = 1'b1;
          end
        end else if (spawn_wr) begin
          if (spawn_ok) do_alloc = 1'b1;
          else          set_err  = 1'b1;
        end
      end
      UPDATE: begin
        if (frame_tick) set_ovr = 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + IDX_W'(1);
        if (spawn_wr) begin
          if (spawn_ok && !pend_q.vld) pend_d  = wr_req;
          else                         set_err = 1'b1;
        end
      end
    endcase
    if (do_alloc && !free_found) set_err = 1'b1;
    load_vec = free_oh & {NUM_BULLETS{do_alloc}};
    if (ctrl_wr) begin
      enable_d = writedata[0];
      speed_d  = writedata[7:4];
    end
    if (kill_wr && writedata[31]) begin
      spawn_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (set_err) spawn_err_d = 1'b1;
    if (set_ovr) overrun_d   = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      enable_q    <= 1'b0;
      speed_q     <= 4'(SPEED_RST);
      spawn_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      enable_q    <= enable_d;
      speed_q     <= speed_d;
      spawn_err_q <= spawn_err_d;
      overrun_q   <= overrun_d;
      pend_q      <= pend_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .X_WIDTH (X_WIDTH),
      .X_MIN   (X_MIN),
      .X_MAX   (X_MAX)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (load_vec[g]),
      .load_x_i   (alloc_x),
      .load_dir_i (alloc_dir),
      .step_i     (step_vec[g]),
      .speed_i    (speed_q),
      .kill_i     (kill_vec[g]),
      .x_o        (slot_x[g]),
      .active_o   (bullet_active[g])
    );
  end

  // Combinational register read mux.
  always_comb begin
    mask4                  = '0;
    mask4[NUM_BULLETS-1:0] = bullet_active;
    readdata               = '0;
    case (address)
      3'd0:    readdata = {20'd0, pend_q.vld, busy, overrun_q, spawn_err_q, 4'd0, mask4};
      3'd1:    readdata = {24'd0, speed_q, 3'd0, enable_q};
      default: begin
        for (int i = 0; i < NUM_BULLETS; i++)
          if (address == 3'(4 + i)) readdata = 32'(slot_x[i]);
      end
    endcase
  end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Bench for bullet_pool_ctrl: directed scenarios plus a randomized run, all
// compared against a frame/slot-level behavioural model of the pool.
module tb_bullet_pool_ctrl;
  localparam int NB   = 4;
  localparam int XW   = 10;
  localparam int XMIN = 0;
  localparam int XMAX = 639;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              frame_tick = 1'b0;
  logic [NB*XW-1:0]  bullet_x;
  logic [NB-1:0]     bullet_active;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_x[NB];
  bit m_act[NB];
  bit m_dir[NB];
  bit m_en, m_err, m_ovr, m_pend, m_pd;
  int m_speed, m_px;
  int m_sweep;   // -1 when idle, else slot handled this cycle

  bullet_pool_ctrl #(.NUM_BULLETS(NB), .X_WIDTH(XW), .X_MIN(XMIN), .X_MAX(XMAX), .SPEED_RST(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_tick(frame_tick), .bullet_x(bullet_x), .bullet_active(bullet_active), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin m_x[i] = 0; m_act[i] = 0; m_dir[i] = 0; end
    m_en = 0; m_speed = 4; m_err = 0; m_ovr = 0; m_pend = 0; m_px = 0; m_pd = 0; m_sweep = -1;
  endtask

  // One clock of the pool, from the rules: sweep step, spawn/queue, CTRL, KILL.
  task automatic model_apply(input bit wr, input logic [2:0] a, input logic [31:0] wd, input bit ft);
    int nx[NB]; bit na[NB]; bit nd[NB];
    bit set_err, set_ovr, spawn, legal, have, sdir, rdir;
    int sx, rx, slot, nsweep;
    nx = m_x; na = m_act; nd = m_dir;
    set_err = 0; set_ovr = 0; have = 0; rx = 0; rdir = 0;
    spawn = wr && (a == 3'd0);
    sx = int'(wd[9:0]); sdir = wd[10];
    legal = (sx >= XMIN) && (sx <= XMAX);
    nsweep = m_sweep;
    if (m_sweep >= 0) begin
      int s = m_sweep;
      if (m_act[s]) begin
        if (!m_dir[s]) begin
          if (m_x[s] + m_speed > XMAX) na[s] = 0; else nx[s] = m_x[s] + m_speed;
        end else begin
          if (m_x[s] - m_speed < XMIN) na[s] = 0; else nx[s] = m_x[s] - m_speed;
        end
      end
      nsweep = (s == NB-1) ? -1 : s + 1;
      if (ft) set_ovr = 1;
      if (spawn) begin
        if (!legal || m_pend) set_err = 1;
        else begin m_pend = 1; m_px = sx; m_pd = sdir; end
      end
    end else begin
      if (ft && m_en) nsweep = 0;
      if (m_pend) begin
        have = 1; rx = m_px; rdir = m_pd; m_pend = 0;
        if (spawn) begin
          if (!legal) set_err = 1;
          else begin m_pend = 1; m_px = sx; m_pd = sdir; end
        end
      end else if (spawn) begin
        if (!legal) set_err = 1;
        else begin have = 1; rx = sx; rdir = sdir; end
      end
      if (have) begin
        slot = -1;
        for (int i = 0; i < NB; i++) if (!m_act[i] && slot < 0) slot = i;
        if (slot < 0) set_err = 1;
        else begin nx[slot] = rx; nd[slot] = rdir; na[slot] = 1; end
      end
    end
    if (wr && a == 3'd1) begin m_en = wd[0]; m_speed = int'(wd[7:4]); end
    if (wr && a == 3'd2) begin
      for (int i = 0; i < NB; i++) if (wd[i]) na[i] = 0;
      if (wd[31]) begin m_err = 0; m_ovr = 0; end
    end
    if (set_err) m_err = 1;
    if (set_ovr) m_ovr = 1;
    m_x = nx; m_act = na; m_dir = nd; m_sweep = nsweep;
  endtask

  function automatic logic [NB-1:0] exp_act();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [NB*XW-1:0] exp_x();
    logic [NB*XW-1:0] v;
    logic [31:0] t;
    for (int i = 0; i < NB; i++) begin t = m_x[i]; v[i*XW +: XW] = t[XW-1:0]; end
    return v;
  endfunction

  function automatic logic [31:0] exp_status();
    int s = 0;
    for (int i = 0; i < NB; i++) if (m_act[i]) s += (1 << i);
    if (m_err) s += 256;
    if (m_ovr) s += 512;
    if (m_sweep >= 0) s += 1024;
    if (m_pend) s += 2048;
    return s;
  endfunction

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic do_cycle(input bit wr, input logic [2:0] a, input logic [31:0] wd, input bit ft);
    chipselect = wr; write_n = !wr; address = a; writedata = wd; frame_tick = ft;
    model_apply(wr, a, wd, ft);
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(0, 3'd0, 32'd0, 0);
  endtask

  task automatic run_frame();
    do_cycle(0, 3'd0, 32'd0, 1);
    idle(NB + 1);
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1; #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; frame_tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rd(3'd0); n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", readdata, 32'h0); end
    rd(3'd1); n_checks++;
    if (readdata !== 32'h40) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=%h", readdata, 32'h40); end
    rd(3'd3); n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL unused_addr got=%h exp=0", readdata); end
    n_checks++;
    if (bullet_x !== '0 || bullet_active !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got x=%h act=%b busy=%b exp all 0", bullet_x, bullet_active, busy);
    end
  endtask

  task automatic test_move_right();
    int busy_cnt;
    do_cycle(1, 3'd1, 32'h41, 0);
    do_cycle(1, 3'd0, 32'd100, 0);
    n_checks++;
    if (bullet_active !== 4'b0001 || bullet_x[9:0] !== 10'd100) begin
      n_fail++; $display("FAIL spawn_100 got act=%b x0=%0d exp act=0001 x0=100", bullet_active, bullet_x[9:0]);
    end
    busy_cnt = 0;
    do_cycle(0, 3'd0, 32'd0, 1);
    if (busy === 1'b1) busy_cnt++;
    repeat (5) begin
      do_cycle(0, 3'd0, 32'd0, 0);
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != NB) begin n_fail++; $display("FAIL busy_len got=%0d exp=%0d", busy_cnt, NB); end
    n_checks++;
    if (bullet_x[9:0] !== 10'd104 || bullet_active !== 4'b0001) begin
      n_fail++; $display("FAIL move_1 got x0=%0d act=%b exp x0=104 act=0001", bullet_x[9:0], bullet_active);
    end
    run_frame();
    n_checks++;
    if (bullet_x[9:0] !== 10'd108) begin n_fail++; $display("FAIL move_2 got x0=%0d exp 108", bullet_x[9:0]); end
  endtask

  task automatic test_boundary();
    do_cycle(1, 3'd2, 32'hF, 0);
    do_cycle(1, 3'd0, 32'd637, 0);
    run_frame();
    rd(3'd4); n_checks++;
    if (bullet_active[0] !== 1'b0 || readdata !== 32'd637) begin
      n_fail++; $display("FAIL retire_right got act0=%b x0=%0d exp act0=0 x0=637", bullet_active[0], readdata);
    end
    do_cycle(1, 3'd0, 32'd4 | 32'h400, 0);
    run_frame();
    n_checks++;
    if (bullet_active[0] !== 1'b1 || bullet_x[9:0] !== 10'd0) begin
      n_fail++; $display("FAIL left_to_min got act0=%b x0=%0d exp act0=1 x0=0", bullet_active[0], bullet_x[9:0]);
    end
    run_frame();
    n_checks++;
    if (bullet_active[0] !== 1'b0 || bullet_x[9:0] !== 10'd0) begin
      n_fail++; $display("FAIL retire_left got act0=%b x0=%0d exp act0=0 x0=0", bullet_active[0], bullet_x[9:0]);
    end
    do_cycle(1, 3'd0, 32'd640, 0);
    rd(3'd0); n_checks++;
    if (readdata !== 32'h100) begin n_fail++; $display("FAIL range_reject got=%h exp=%h", readdata, 32'h100); end
    do_cycle(1, 3'd2, 32'h80000000, 0);
  endtask

  task automatic test_full_pool();
    for (int i = 1; i <= 5; i++) do_cycle(1, 3'd0, 32'(i * 10), 0);
    rd(3'd0); n_checks++;
    if (readdata !== 32'h10F) begin n_fail++; $display("FAIL pool_full got=%h exp=%h", readdata, 32'h10F); end
    do_cycle(1, 3'd2, 32'h80000002, 0);
    rd(3'd0); n_checks++;
    if (readdata !== 32'h00D) begin n_fail++; $display("FAIL kill_clear got=%h exp=%h", readdata, 32'h00D); end
    do_cycle(1, 3'd0, 32'd300, 0);
    rd(3'd5); n_checks++;
    if (readdata !== 32'd300 || bullet_active !== 4'b1111) begin
      n_fail++; $display("FAIL refill_slot1 got x1=%0d act=%b exp x1=300 act=1111", readdata, bullet_active);
    end
  endtask

  task automatic test_pending();
    int waited;
    do_cycle(1, 3'd2, 32'h8000000F, 0);
    do_cycle(1, 3'd0, 32'd50, 0);
    do_cycle(0, 3'd0, 32'd0, 1);
    do_cycle(1, 3'd0, 32'd200, 0);
    rd(3'd0); n_checks++;
    if (readdata !== 32'hC01) begin n_fail++; $display("FAIL pending_status got=%h exp=%h", readdata, 32'hC01); end
    waited = 0;
    while (busy === 1'b1 && waited < 10) begin idle(1); waited++; end
    n_checks++;
    if (waited != 3 || busy !== 1'b0) begin n_fail++; $display("FAIL sweep_end got waited=%0d busy=%b exp 3 0", waited, busy); end
    n_checks++;
    if (bullet_active !== 4'b0001) begin n_fail++; $display("FAIL pending_hold got act=%b exp 0001", bullet_active); end
    idle(1);
    n_checks++;
    if (bullet_active !== 4'b0011 || bullet_x[19:10] !== 10'd200 || bullet_x[9:0] !== 10'd54) begin
      n_fail++; $display("FAIL pending_apply got act=%b x1=%0d x0=%0d exp 0011 200 54", bullet_active, bullet_x[19:10], bullet_x[9:0]);
    end
    do_cycle(0, 3'd0, 32'd0, 1);
    do_cycle(1, 3'd0, 32'd60, 0);
    do_cycle(1, 3'd0, 32'd70, 0);
    rd(3'd0); n_checks++;
    if (readdata[11] !== 1'b1 || readdata[8] !== 1'b1) begin
      n_fail++; $display("FAIL double_pending got pend=%b err=%b exp 1 1", readdata[11], readdata[8]);
    end
    idle(5);
    n_checks++;
    if (bullet_active !== 4'b0111 || bullet_x[29:20] !== 10'd60) begin
      n_fail++; $display("FAIL first_kept got act=%b x2=%0d exp 0111 60", bullet_active, bullet_x[29:20]);
    end
  endtask

  task automatic test_kill_during_sweep();
    do_cycle(1, 3'd2, 32'h8000000F, 0);
    do_cycle(1, 3'd0, 32'd100, 0);
    do_cycle(1, 3'd0, 32'd200, 0);
    do_cycle(1, 3'd0, 32'd300, 0);
    do_cycle(0, 3'd0, 32'd0, 1);
    do_cycle(0, 3'd0, 32'd0, 0);
    do_cycle(0, 3'd0, 32'd0, 1);
    do_cycle(1, 3'd2, 32'h4, 0);
    n_checks++;
    if (bullet_active !== 4'b0011 || bullet_x[9:0] !== 10'd104 || bullet_x[19:10] !== 10'd204) begin
      n_fail++; $display("FAIL kill_vs_update got act=%b x0=%0d x1=%0d exp 0011 104 204", bullet_active, bullet_x[9:0], bullet_x[19:10]);
    end
    rd(3'd0); n_checks++;
    if (readdata !== 32'h603) begin n_fail++; $display("FAIL overrun_status got=%h exp=%h", readdata, 32'h603); end
    idle(2);
  endtask

  task automatic test_reset_mid_sweep();
    do_cycle(0, 3'd0, 32'd0, 1);
    do_cycle(1, 3'd0, 32'd123, 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got=%b exp 1", busy); end
    reset_n = 1'b0; #1;
    n_checks++;
    if (bullet_active !== '0 || bullet_x !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got act=%b x=%h busy=%b exp all 0", bullet_active, bullet_x, busy);
    end
    rd(3'd1); n_checks++;
    if (readdata !== 32'h40) begin n_fail++; $display("FAIL reset_ctrl2 got=%h exp=%h", readdata, 32'h40); end
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    idle(3);
    rd(3'd0); n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL pending_lost got=%h exp 0", readdata); end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    int r;
    bit ft;
    do_cycle(1, 3'd1, 32'h31, 0);
    for (int c = 0; c < 800; c++) begin
      r  = $urandom_range(0, 99);
      ft = ($urandom_range(0, 3) == 0);
      if (r < 25) begin
        wd = $urandom_range(0, 700);
        wd[10] = 1'($urandom_range(0, 1));
        do_cycle(1, 3'd0, wd, ft);
      end else if (r < 32) begin
        wd = $urandom_range(0, 15);
        wd[31] = ($urandom_range(0, 2) == 0);
        do_cycle(1, 3'd2, wd, ft);
      end else if (r < 38) begin
        wd = {24'd0, 4'($urandom_range(0, 15)), 3'd0, 1'($urandom_range(0, 5) != 0)};
        do_cycle(1, 3'd1, wd, ft);
      end else if (r < 42) begin
        do_cycle(1, 3'(3 + $urandom_range(0, 4)), $urandom, ft);
      end else begin
        do_cycle(0, 3'd0, 32'd0, ft);
      end
      n_checks++;
      if (bullet_active !== exp_act() || bullet_x !== exp_x() || busy !== (m_sweep >= 0)) begin
        n_fail++;
        $display("FAIL rnd_outputs cyc=%0d got act=%b x=%h busy=%b exp act=%b x=%h busy=%b",
                 c, bullet_active, bullet_x, busy, exp_act(), exp_x(), (m_sweep >= 0));
      end
      rd(3'd0); n_checks++;
      if (readdata !== exp_status()) begin
        n_fail++; $display("FAIL rnd_status cyc=%0d got=%h exp=%h", c, readdata, exp_status());
      end
      if (c % 8 == 0) begin
        rd(3'd1); n_checks++;
        if (readdata !== 32'(m_speed * 16 + int'(m_en))) begin
          n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", c, readdata, 32'(m_speed * 16 + int'(m_en)));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_right();
    test_boundary();
    test_full_pool();
    test_pending();
    test_kill_during_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
